// File: rtl/flag_pkg.sv
// Shared flag bit positions and the flag vector type used by the flag unit,
// the control unit and the branch logic.
package flag_pkg;
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_V = 3;
  localparam int FLAG_P = 4;
  localparam int NFLAGS = 5;

  typedef logic [NFLAGS-1:0] flags_t;
endpackage

// File: rtl/flag_stack.sv
// LIFO of saved flag vectors for CALL/RET and interrupt entry/exit; supports
// push, pop and a same-cycle swap, and flags overflow/underflow attempts.
import flag_pkg::*;

module flag_stack #(
  parameter int STACK_DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_push,
  input  logic   i_pop,
  input  flags_t i_din,
  output flags_t o_top,
  output logic   o_full,
  output logic   o_empty,
  output logic   o_pop_ok,
  output logic   o_err
);
  localparam int PW   = $clog2(STACK_DEPTH + 1);
  // Storage rounded up to the pointer range so every index is in bounds.
  localparam int NENT = 1 << PW;

  logic [PW-1:0] r_depth;
  flags_t        r_mem [NENT];

  logic          w_full;
  logic          w_empty;
  logic          w_pop_ok;
  logic          w_push_ok;
  logic [PW-1:0] w_top_idx;
  logic [PW-1:0] w_wr_idx;

  assign w_full    = (r_depth == PW'(STACK_DEPTH));
  assign w_empty   = (r_depth == '0);
  assign w_pop_ok  = i_pop & ~w_empty;
  // A push on a full stack still succeeds when it is a swap with a pop.
  assign w_push_ok = i_push & (~w_full | w_pop_ok);
  assign w_top_idx = r_depth - PW'(1);
  assign w_wr_idx  = w_pop_ok ? w_top_idx : r_depth;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_depth <= '0;
    end else if (w_push_ok && !w_pop_ok) begin
      r_depth <= r_depth + PW'(1);
    end else if (w_pop_ok && !w_push_ok) begin
      r_depth <= r_depth - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[w_wr_idx] <= i_din;
    end
  end

  assign o_top    = r_mem[w_top_idx];
  assign o_full   = w_full;
  assign o_empty  = w_empty;
  assign o_pop_ok = w_pop_ok;
  assign o_err    = (i_pop & w_empty) | (i_push & ~i_pop & w_full);
endmodule

// File: rtl/flag_unit.sv
// Processor flag register (C,Z,S,V,P) with masked ALU update, direct load and
// a save/restore stack. Define FLAG_STICKY_OVF_EN to make V sticky under update.
import flag_pkg::*;

module flag_unit #(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] res,
  input  logic             cout,
  input  logic             vin,
  input  logic             upd_en,
  input  logic [4:0]       upd_mask,
  input  logic             wr_en,
  input  logic [4:0]       wr_data,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_err,
  output logic [4:0]       f,
  output logic             stk_full,
  output logic             stk_empty,
  output logic             stk_err
);
  flags_t r_f;
  logic   r_stk_err;
  flags_t w_calc;
  flags_t w_upd;
  flags_t w_f_nxt;
  flags_t w_top;
  logic   w_pop_ok;
  logic   w_err;

  always_comb begin
    w_calc         = '0;
    w_calc[FLAG_C] = cout;
    w_calc[FLAG_Z] = (res == '0);
    w_calc[FLAG_S] = res[WIDTH-1];
    w_calc[FLAG_V] = vin;
    w_calc[FLAG_P] = ~^res;
  end

  always_comb begin
    w_upd = (r_f & ~upd_mask) | (w_calc & upd_mask);
`ifdef FLAG_STICKY_OVF_EN
    // Once set, V can only be cleared by a direct load or a restore.
    w_upd[FLAG_V] = r_f[FLAG_V] | (upd_mask[FLAG_V] & vin);
`endif
  end

  always_comb begin
    w_f_nxt = r_f;
    if (w_pop_ok) begin
      w_f_nxt = w_top;
    end else if (wr_en) begin
      w_f_nxt = wr_data;
    end else if (upd_en) begin
      w_f_nxt = w_upd;
    end
  end

  // The stack saves r_f as registered before this edge, never the update.
  flag_stack #(
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (push),
    .i_pop    (pop),
    .i_din    (r_f),
    .o_top    (w_top),
    .o_full   (stk_full),
    .o_empty  (stk_empty),
    .o_pop_ok (w_pop_ok),
    .o_err    (w_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f       <= '0;
      r_stk_err <= 1'b0;
    end else begin
      r_f <= w_f_nxt;
      if (w_err) begin
        r_stk_err <= 1'b1;
      end else if (clr_err) begin
        r_stk_err <= 1'b0;
      end
    end
  end

  assign f       = r_f;
  assign stk_err = r_stk_err;
endmodule

// File: tb/tb_flag_unit.sv
// Directed and random stimulus for flag_unit, checked against a queue-based
// reference model of the flag and stack rules.
module tb_flag_unit;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] res;
  logic         cout, vin, upd_en, wr_en, push, pop, clr_err;
  logic [4:0]   upd_mask, wr_data;
  logic [4:0]   f;
  logic         stk_full, stk_empty, stk_err;

  int errors = 0;
  int checks = 0;

  logic [4:0] m_f;
  logic       m_err;
  logic [4:0] m_q[$];

  flag_unit #(.WIDTH(W), .STACK_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .res(res), .cout(cout), .vin(vin),
    .upd_en(upd_en), .upd_mask(upd_mask), .wr_en(wr_en), .wr_data(wr_data),
    .push(push), .pop(pop), .clr_err(clr_err), .f(f),
    .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_f = '0;
    m_err = 1'b0;
    m_q.delete();
  endtask

  task automatic model_edge();
    logic [4:0] old_f, calc, nf;
    bit         pop_ok, e;
    int         n;
    n         = m_q.size();
    old_f     = m_f;
    calc[0]   = cout;
    calc[1]   = (res == 0);
    calc[2]   = (res >= (1 << (W - 1)));
    calc[3]   = vin;
    calc[4]   = ($countones(res) % 2 == 0);
    pop_ok    = pop && (n > 0);
    if (pop_ok) nf = m_q[n-1];
    else if (wr_en) nf = wr_data;
    else if (upd_en) begin
      for (int i = 0; i < 5; i++) nf[i] = upd_mask[i] ? calc[i] : old_f[i];
`ifdef FLAG_STICKY_OVF_EN
      if (upd_mask[3]) nf[3] = old_f[3] | vin;
`endif
    end else nf = old_f;
    e = (pop && n == 0) || (push && !pop && n == D);
    if (push && pop_ok) m_q[n-1] = old_f;
    else if (push && n < D) m_q.push_back(old_f);
    else if (pop_ok) void'(m_q.pop_back());
    m_f = nf;
    if (e) m_err = 1'b1;
    else if (clr_err) m_err = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_f"}, f, m_f);
    chk({tag, "_empty"}, stk_empty, m_q.size() == 0);
    chk({tag, "_full"}, stk_full, m_q.size() == D);
    chk({tag, "_err"}, stk_err, m_err);
  endtask

  task automatic idle();
    res = '0; cout = 0; vin = 0; upd_en = 0; upd_mask = '0;
    wr_en = 0; wr_data = '0; push = 0; pop = 0; clr_err = 0;
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    idle();
  endtask

  task automatic do_upd(input logic [7:0] r, input logic c, input logic v, input logic [4:0] m);
    upd_en = 1; res = r; cout = c; vin = v; upd_mask = m;
  endtask

  task automatic do_wr(input logic [4:0] d);
    wr_en = 1; wr_data = d;
  endtask

  initial begin
    logic [4:0] exp_pops [4];
    exp_pops[0] = 5'h0A; exp_pops[1] = 5'h05; exp_pops[2] = 5'h05; exp_pops[3] = 5'h05;
    idle();
    rst_n = 0;
    model_reset();
    #8;
    chk("rst_f", f, 5'h00);
    chk("rst_empty", stk_empty, 1'b1);
    chk("rst_full", stk_full, 1'b0);
    chk("rst_err", stk_err, 1'b0);
    #4 rst_n = 1;

    do_upd(8'h00, 1, 0, 5'h1F); cyc("upd_zero");
    chk("tp_zero_f", f, 5'b10011);
    do_upd(8'h80, 0, 1, 5'b01100); cyc("upd_mask");
    chk("tp_mask_f", f, 5'b11111);

    do_wr(5'h05); cyc("ld05");
    for (int i = 0; i < 3; i++) begin push = 1; cyc("push05"); end
    do_wr(5'h0A); cyc("ld0A");
    push = 1; cyc("push0A");
    chk("tp_full", stk_full, 1'b1);
    push = 1; cyc("push_ovf");
    chk("tp_ovf_err", stk_err, 1'b1);
    for (int i = 0; i < 4; i++) begin
      pop = 1; cyc("pop_seq");
      chk("tp_pop_val", f, exp_pops[i]);
    end
    chk("tp_pop_empty", stk_empty, 1'b1);
    clr_err = 1; cyc("clr");

    do_wr(5'h10); cyc("ld10");
    push = 1; cyc("push10");
    do_wr(5'h03); cyc("ld03");
    push = 1; pop = 1; cyc("swap");
    chk("tp_swap_f", f, 5'h10);
    pop = 1; cyc("pop_after_swap");
    chk("tp_swap_top", f, 5'h03);
    push = 1; pop = 1; cyc("swap_empty");
    chk("tp_swap_empty_err", stk_err, 1'b1);
    chk("tp_swap_empty_depth1", stk_empty, 1'b0);
    pop = 1; do_wr(5'h1F); cyc("pop_vs_wr");
    chk("tp_pop_beats_wr", f, 5'h03);
    clr_err = 1; cyc("clr2");
    clr_err = 1; pop = 1; cyc("clr_vs_unf");
    chk("tp_clr_vs_unf", stk_err, 1'b1);
    clr_err = 1; cyc("clr3");

    do_upd(8'h01, 0, 1, 5'b01000); cyc("v_set");
    do_upd(8'h01, 0, 0, 5'b01000); cyc("v_clear_try");
`ifdef FLAG_STICKY_OVF_EN
    chk("tp_v_sticky", f[3], 1'b1);
`else
    chk("tp_v_follow", f[3], 1'b0);
`endif

    for (int i = 0; i < 400; i++) begin
      res = 8'($urandom);
      cout = 1'($urandom);
      vin = 1'($urandom);
      upd_en = 1'($urandom);
      upd_mask = 5'($urandom);
      wr_en = ($urandom_range(0, 3) == 0);
      wr_data = 5'($urandom);
      push = ($urandom_range(0, 2) == 0);
      pop = ($urandom_range(0, 2) == 0);
      clr_err = ($urandom_range(0, 7) == 0);
      cyc("rand");
    end

    push = 1; do_wr(5'h1F);
    @(posedge clk);
    model_edge();
    #3 rst_n = 0;
    #1;
    model_reset();
    chk("arst_f", f, 5'h00);
    chk("arst_empty", stk_empty, 1'b1);
    chk("arst_err", stk_err, 1'b0);
    #1 rst_n = 1;
    idle();
    do_upd(8'h7F, 0, 0, 5'h1F); cyc("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
